// File: rtl/uart_rx.sv
//-----------------------------------------------------------------------------
// uart_rx
//
// Serial receiver clocked at the bit rate (one uart_clk cycle per line bit,
// one sample per bit). Frame format: start bit (0), DATA_WIDTH data bits
// LSB first, one parity bit, one stop bit (1). Each frame is deserialized,
// parity and stop bit are checked, and the word is offered downstream on a
// valid/ready handshake.
//
// Parameters
//   DATA_WIDTH    data bits per frame (frame is DATA_WIDTH+3 bits long)
//   PARITY_ODD    1 = odd parity, 0 = even parity
//
// Ports
//   uart_clk       in   bit-rate clock
//   rst_n          in   asynchronous active-low reset
//   rx_in          in   serial line, idle high, asynchronous to uart_clk
//   rx_ready       in   consumer takes the word on an edge with rx_valid=1
//   rx_data        out  received word
//   rx_valid       out  rx_data and error flags valid, held until accepted
//   rx_parity_err  out  parity mismatch for the word in rx_data
//   rx_frame_err   out  stop bit sampled 0 for the word in rx_data
//   rx_overrun     out  one-cycle pulse: an unaccepted word was overwritten
//   rx_busy        out  high while a frame is being received
//-----------------------------------------------------------------------------
module uart_rx #(
   parameter int DATA_WIDTH = 8,
   parameter bit PARITY_ODD = 1'b1
) (
   input  logic                  uart_clk,
   input  logic                  rst_n,
   input  logic                  rx_in,
   input  logic                  rx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  rx_parity_err,
   output logic                  rx_frame_err,
   output logic                  rx_overrun,
   output logic                  rx_busy
);

   localparam int               CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic             PAR_ODD  = PARITY_ODD;

   typedef enum logic [2:0] {
      ST_ARM    = 3'd0,
      ST_IDLE   = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   // True when data ones plus the parity bit disagree with the selected parity.
   function automatic logic parity_bad(input logic acc, input logic par_bit);
      return ((acc ^ par_bit) != PAR_ODD);
   endfunction

   // Synchronizer and its warm-up qualifier
   logic                  sync1_r;
   logic                  sync2_r;
   logic                  rx_s;
   logic [1:0]            warm_r;

   // FSM
   state_t                state_r;
   state_t                state_nx_s;
   logic                  start_s;
   logic                  shift_en_s;
   logic                  par_en_s;
   logic                  done_s;
   logic                  busy_nx_s;

   // Datapath
   logic [CNT_W-1:0]      bit_cnt_r;
   logic [DATA_WIDTH-1:0] shift_r;
   logic                  acc_r;
   logic                  par_err_r;

   // Output registers
   logic [DATA_WIDTH-1:0] rx_data_r;
   logic                  rx_valid_r;
   logic                  rx_parity_err_r;
   logic                  rx_frame_err_r;
   logic                  rx_overrun_r;
   logic                  rx_busy_r;

   assign rx_s          = sync2_r;
   assign rx_data       = rx_data_r;
   assign rx_valid      = rx_valid_r;
   assign rx_parity_err = rx_parity_err_r;
   assign rx_frame_err  = rx_frame_err_r;
   assign rx_overrun    = rx_overrun_r;
   assign rx_busy       = rx_busy_r;

   // Two-flop synchronizer on the asynchronous line, idle-high reset values.
   // warm_r fills with ones over the first two edges after reset; until then
   // rx_s still carries the reset value rather than a real line sample, so
   // ARM must not treat it as evidence of an idle line.
   always_ff @(posedge uart_clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
         warm_r  <= 2'b00;
      end else begin
         sync1_r <= rx_in;
         sync2_r <= sync1_r;
         warm_r  <= {warm_r[0], 1'b1};
      end
   end

   // FSM state register.
   always_ff @(posedge uart_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_ARM;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // FSM next-state and per-state datapath strobes.
   always_comb begin
      state_nx_s = state_r;
      start_s    = 1'b0;
      shift_en_s = 1'b0;
      par_en_s   = 1'b0;
      done_s     = 1'b0;
      case (state_r)
         ST_ARM: begin
            // Wait for a genuinely sampled high line before hunting for a
            // start bit, so a reset or break mid-frame cannot fake one.
            if (warm_r[1] && rx_s) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_ARM;
            end
         end
         ST_IDLE: begin
            if (!rx_s) begin
               state_nx_s = ST_DATA;
               start_s    = 1'b1;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_DATA: begin
            shift_en_s = 1'b1;
            if (bit_cnt_r == LAST_CNT) begin
               state_nx_s = ST_PARITY;
            end else begin
               state_nx_s = ST_DATA;
            end
         end
         ST_PARITY: begin
            par_en_s   = 1'b1;
            state_nx_s = ST_STOP;
         end
         ST_STOP: begin
            done_s = 1'b1;
            // A low stop bit may be the start of a break: re-arm.
            if (rx_s) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_ARM;
            end
         end
         default: begin
            state_nx_s = ST_ARM;
         end
      endcase
      busy_nx_s = (state_nx_s == ST_DATA) || (state_nx_s == ST_PARITY) ||
                  (state_nx_s == ST_STOP);
   end

   // Deserializer: bit counter, shift register and running parity.
   always_ff @(posedge uart_clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt_r <= {CNT_W{1'b0}};
         shift_r   <= {DATA_WIDTH{1'b0}};
         acc_r     <= 1'b0;
         par_err_r <= 1'b0;
      end else begin
         if (start_s) begin
            bit_cnt_r <= {CNT_W{1'b0}};
            acc_r     <= 1'b0;
         end else if (shift_en_s) begin
            shift_r[bit_cnt_r] <= rx_s;
            acc_r              <= acc_r ^ rx_s;
            // Return to zero after the last bit instead of counting past it.
            if (bit_cnt_r == LAST_CNT) begin
               bit_cnt_r <= {CNT_W{1'b0}};
            end else begin
               bit_cnt_r <= bit_cnt_r + CNT_ONE;
            end
         end
         if (par_en_s) begin
            par_err_r <= parity_bad(acc_r, rx_s);
         end
      end
   end

   // Output word, flags and valid/ready handshake. A completing frame always
   // wins over an accept on the same edge: the new word is loaded and valid
   // stays high; overrun pulses only if the old word was not being taken.
   always_ff @(posedge uart_clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data_r       <= {DATA_WIDTH{1'b0}};
         rx_valid_r      <= 1'b0;
         rx_parity_err_r <= 1'b0;
         rx_frame_err_r  <= 1'b0;
         rx_overrun_r    <= 1'b0;
         rx_busy_r       <= 1'b0;
      end else begin
         rx_busy_r <= busy_nx_s;
         if (done_s) begin
            rx_data_r       <= shift_r;
            rx_parity_err_r <= par_err_r;
            rx_frame_err_r  <= ~rx_s;
            rx_valid_r      <= 1'b1;
            rx_overrun_r    <= rx_valid_r & ~rx_ready;
         end else begin
            rx_overrun_r <= 1'b0;
            if (rx_valid_r && rx_ready) begin
               rx_valid_r <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
//-----------------------------------------------------------------------------
// tb_uart_rx
//
// Directed bench for uart_rx (DATA_WIDTH=8, odd parity). Inputs change and
// outputs are sampled on the falling edge; the DUT acts on the rising edge.
// Frames are built from hand-chosen data, parity and stop bits.
//-----------------------------------------------------------------------------
module tb_uart_rx;

   localparam int DW = 8;

   logic          uart_clk;
   logic          rst_n;
   logic          rx_in;
   logic          rx_ready;
   logic [DW-1:0] rx_data;
   logic          rx_valid;
   logic          rx_parity_err;
   logic          rx_frame_err;
   logic          rx_overrun;
   logic          rx_busy;

   int   checks   = 0;
   int   passes   = 0;
   int   rise_cnt = 0;
   int   ovr_cnt  = 0;
   logic prev_valid = 1'b0;

   uart_rx #(.DATA_WIDTH(DW), .PARITY_ODD(1'b1)) dut (
      .uart_clk      (uart_clk),
      .rst_n         (rst_n),
      .rx_in         (rx_in),
      .rx_ready      (rx_ready),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_parity_err (rx_parity_err),
      .rx_frame_err  (rx_frame_err),
      .rx_overrun    (rx_overrun),
      .rx_busy       (rx_busy)
   );

   initial begin
      uart_clk = 1'b0;
      forever #5 uart_clk = ~uart_clk;
   end

   // Event recorder: counts rx_valid rising edges and rx_overrun cycles.
   always @(posedge uart_clk) begin
      #1;
      if (rx_valid === 1'b1 && prev_valid !== 1'b1) rise_cnt++;
      if (rx_overrun === 1'b1) ovr_cnt++;
      prev_valid = rx_valid;
   end

   task automatic tick();
      @(posedge uart_clk);
      @(negedge uart_clk);
   endtask

   // Drives one full frame, one line bit per clock, start bit first.
   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
      logic [10:0] f;
      f = {stop, par, d, 1'b0};
      for (int i = 0; i < 11; i++) begin
         rx_in = f[i];
         tick();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rx_in = 1'b1; rx_ready = 1'b0;
      tick(); tick();
      checks++; if (rx_data !== 8'h00) $display("FAIL reset_data: got %h want 00", rx_data); else passes++;
      checks++; if (rx_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rx_valid); else passes++;
      checks++; if (rx_parity_err !== 1'b0) $display("FAIL reset_perr: got %b want 0", rx_parity_err); else passes++;
      checks++; if (rx_frame_err !== 1'b0) $display("FAIL reset_ferr: got %b want 0", rx_frame_err); else passes++;
      checks++; if (rx_overrun !== 1'b0) $display("FAIL reset_ovr: got %b want 0", rx_overrun); else passes++;
      checks++; if (rx_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", rx_busy); else passes++;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) tick();
   endtask

   task automatic test_good_frame();
      rx_ready = 1'b1;
      send_frame(8'hA5, 1'b1, 1'b1);   // 0xA5 has four ones -> odd parity bit 1
      rx_in = 1'b1;
      checks++; if (rx_busy !== 1'b1) $display("FAIL good_busy: got %b want 1", rx_busy); else passes++;
      tick();                          // edge E+11
      checks++; if (rx_valid !== 1'b0) $display("FAIL good_early: valid %b want 0", rx_valid); else passes++;
      tick();                          // edge E+12
      checks++; if (rx_valid !== 1'b1) $display("FAIL good_valid: got %b want 1", rx_valid); else passes++;
      checks++; if (rx_data !== 8'hA5) $display("FAIL good_data: got %h want a5", rx_data); else passes++;
      checks++; if (rx_parity_err !== 1'b0) $display("FAIL good_perr: got %b want 0", rx_parity_err); else passes++;
      checks++; if (rx_frame_err !== 1'b0) $display("FAIL good_ferr: got %b want 0", rx_frame_err); else passes++;
      checks++; if (rx_busy !== 1'b0) $display("FAIL good_busy_end: got %b want 0", rx_busy); else passes++;
      tick();
      checks++; if (rx_valid !== 1'b0) $display("FAIL good_accept: valid %b want 0", rx_valid); else passes++;
   endtask

   task automatic test_parity_err();
      rx_ready = 1'b1;
      send_frame(8'h00, 1'b0, 1'b1);   // odd parity needs 1 here
      rx_in = 1'b1;
      tick(); tick();
      checks++; if (rx_valid !== 1'b1) $display("FAIL par_valid: got %b want 1", rx_valid); else passes++;
      checks++; if (rx_data !== 8'h00) $display("FAIL par_data: got %h want 00", rx_data); else passes++;
      checks++; if (rx_parity_err !== 1'b1) $display("FAIL par_perr: got %b want 1", rx_parity_err); else passes++;
      checks++; if (rx_frame_err !== 1'b0) $display("FAIL par_ferr: got %b want 0", rx_frame_err); else passes++;
      tick();
   endtask

   task automatic test_hold_until_ready();
      rx_ready = 1'b0;
      send_frame(8'hC3, 1'b1, 1'b1);   // four ones -> parity 1
      rx_in = 1'b1;
      tick(); tick();
      for (int i = 0; i < 2; i++) begin
         tick();                       // rx_ready low on this edge
         checks++; if (rx_valid !== 1'b1) $display("FAIL hold_valid%0d: got %b want 1", i, rx_valid); else passes++;
         checks++; if (rx_data !== 8'hC3) $display("FAIL hold_data%0d: got %h want c3", i, rx_data); else passes++;
      end
      rx_ready = 1'b1;
      tick();
      checks++; if (rx_valid !== 1'b0) $display("FAIL hold_accept: valid %b want 0", rx_valid); else passes++;
   endtask

   task automatic test_frame_err();
      int rise_base, ovr_base, busy_seen;
      rx_ready  = 1'b0;
      rise_base = rise_cnt;
      ovr_base  = ovr_cnt;
      busy_seen = 0;
      send_frame(8'h3C, 1'b1, 1'b0);   // stop bit 0; line stays low
      tick(); tick();
      checks++; if (rx_valid !== 1'b1) $display("FAIL ferr_valid: got %b want 1", rx_valid); else passes++;
      checks++; if (rx_data !== 8'h3C) $display("FAIL ferr_data: got %h want 3c", rx_data); else passes++;
      checks++; if (rx_frame_err !== 1'b1) $display("FAIL ferr_ferr: got %b want 1", rx_frame_err); else passes++;
      checks++; if (rx_parity_err !== 1'b0) $display("FAIL ferr_perr: got %b want 0", rx_parity_err); else passes++;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (rx_busy === 1'b1) busy_seen++;
      end
      rx_in = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (rx_busy === 1'b1) busy_seen++;
      end
      checks++; if (busy_seen !== 0) $display("FAIL ferr_no_decode: busy cycles %0d want 0", busy_seen); else passes++;
      checks++; if (rise_cnt - rise_base !== 1) $display("FAIL ferr_words: got %0d want 1", rise_cnt - rise_base); else passes++;
      checks++; if (ovr_cnt - ovr_base !== 0) $display("FAIL ferr_ovr: got %0d want 0", ovr_cnt - ovr_base); else passes++;
      checks++; if (rx_data !== 8'h3C) $display("FAIL ferr_kept: got %h want 3c", rx_data); else passes++;
   endtask

   // Entered with 0x3C still pending, so both the first and second
   // completions overwrite an unaccepted word.
   task automatic test_back_to_back();
      int ovr_base;
      rx_ready = 1'b0;
      ovr_base = ovr_cnt;
      send_frame(8'h01, 1'b0, 1'b1);
      send_frame(8'h80, 1'b0, 1'b1);
      send_frame(8'hFF, 1'b1, 1'b1);
      rx_in = 1'b1;
      tick();                          // third frame edge E+11
      checks++; if (rx_valid !== 1'b1) $display("FAIL b2b_mid_valid: got %b want 1", rx_valid); else passes++;
      checks++; if (rx_data !== 8'h80) $display("FAIL b2b_mid_data: got %h want 80", rx_data); else passes++;
      rx_ready = 1'b1;
      tick();                          // completion with ready high
      checks++; if (rx_valid !== 1'b1) $display("FAIL b2b_valid: got %b want 1", rx_valid); else passes++;
      checks++; if (rx_data !== 8'hFF) $display("FAIL b2b_data: got %h want ff", rx_data); else passes++;
      checks++; if (rx_parity_err !== 1'b0) $display("FAIL b2b_perr: got %b want 0", rx_parity_err); else passes++;
      checks++; if (rx_frame_err !== 1'b0) $display("FAIL b2b_ferr: got %b want 0", rx_frame_err); else passes++;
      checks++; if (rx_overrun !== 1'b0) $display("FAIL b2b_no_ovr: got %b want 0", rx_overrun); else passes++;
      tick();
      checks++; if (rx_valid !== 1'b0) $display("FAIL b2b_accept: valid %b want 0", rx_valid); else passes++;
      checks++; if (ovr_cnt - ovr_base !== 2) $display("FAIL b2b_ovr_count: got %0d want 2", ovr_cnt - ovr_base); else passes++;
   endtask

   task automatic test_reset_mid_frame();
      int rise_base, busy_seen;
      rx_ready  = 1'b1;
      rx_in     = 1'b1;
      busy_seen = 0;
      tick();
      rise_base = rise_cnt;
      rx_in = 1'b0; tick();            // start bit
      for (int i = 0; i < 4; i++) begin
         rx_in = 1'b1; tick();         // four data bits
      end
      checks++; if (rx_busy !== 1'b1) $display("FAIL rst_pre_busy: got %b want 1", rx_busy); else passes++;
      rst_n = 1'b0;
      #1;
      checks++; if (rx_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", rx_busy); else passes++;
      checks++; if (rx_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", rx_valid); else passes++;
      rx_in = 1'b0;
      tick(); tick();
      rst_n = 1'b1;                    // released with the line low
      for (int i = 0; i < 4; i++) begin
         tick();
         if (rx_busy === 1'b1) busy_seen++;
      end
      rx_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (rx_busy === 1'b1) busy_seen++;
      end
      checks++; if (busy_seen !== 0) $display("FAIL rst_low_ignored: busy cycles %0d want 0", busy_seen); else passes++;
      send_frame(8'h5A, 1'b1, 1'b1);   // four ones -> parity 1
      rx_in = 1'b1;
      tick(); tick();
      checks++; if (rx_valid !== 1'b1) $display("FAIL rst_5a_valid: got %b want 1", rx_valid); else passes++;
      checks++; if (rx_data !== 8'h5A) $display("FAIL rst_5a_data: got %h want 5a", rx_data); else passes++;
      checks++; if (rx_parity_err !== 1'b0) $display("FAIL rst_5a_perr: got %b want 0", rx_parity_err); else passes++;
      checks++; if (rx_frame_err !== 1'b0) $display("FAIL rst_5a_ferr: got %b want 0", rx_frame_err); else passes++;
      checks++; if (rise_cnt - rise_base !== 1) $display("FAIL rst_words: got %0d want 1", rise_cnt - rise_base); else passes++;
      tick();
   endtask

   initial begin
      rst_n    = 1'b0;
      rx_in    = 1'b1;
      rx_ready = 1'b0;
      @(negedge uart_clk);
      test_reset();
      test_good_frame();
      test_parity_err();
      test_hold_until_ready();
      test_frame_err();
      test_back_to_back();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
